// File: rtl/text_buffer.sv
// text_buffer: 7x20 character-cell store feeding the glyph mapper.
// Bytes arrive over valid/ready and update cells and the cursor. Clear and
// scroll run as 140-cycle sweeps through the single write port. The mapper's
// read port stays live the whole time.
module text_buffer #(
    parameter int          ROWS  = 7,
    parameter int          COLS  = 20,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] rin,
    input  logic [5:0] cin,
    output logic [7:0] charout,
    output logic [2:0] cur_row,
    output logic [4:0] cur_col,
    output logic       busy
);

    localparam int         CELLS     = ROWS * COLS;
    localparam logic [7:0] LAST      = 8'(CELLS - 1);
    localparam logic [7:0] SHIFT_END = 8'(CELLS - COLS);  // first cell of the bottom row
    localparam logic [7:0] COLS8     = 8'(COLS);
    localparam logic [2:0] ROW_MAX   = 3'(ROWS - 1);
    localparam logic [4:0] COL_MAX   = 5'(COLS - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, SCROLL} state_t;

    state_t     state_q, state_d;
    logic [7:0] k_q, k_d;          // sweep index
    logic [2:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic [7:0] charout_q;
    logic [7:0] mem_q [CELLS];

    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       accept;
    logic [7:0] cur_idx;
    logic [7:0] src_idx;
    logic [7:0] rd_idx;
    logic       rd_oob;

    function automatic logic [7:0] cell_idx(input logic [2:0] r, input logic [4:0] c);
        return ({5'd0, r} * COLS8) + {3'd0, c};
    endfunction

    assign in_ready = (state_q == IDLE) && !reset;
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;
    assign cur_idx  = cell_idx(row_q, col_q);
    // Scroll source is one row below; clamp once the sweep reaches the bottom row.
    assign src_idx  = (k_q < SHIFT_END) ? (k_q + COLS8) : k_q;
    // Range check is on the full port widths; the index is only used when in range.
    assign rd_oob   = (rin >= 4'(ROWS)) || (cin >= 6'(COLS));
    assign rd_idx   = ({4'd0, rin} * COLS8) + {2'd0, cin};

    assign charout = charout_q;
    assign cur_row = row_q;
    assign cur_col = col_q;

    // Next-state, cursor and single write-port control.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        we      = 1'b0;
        waddr   = k_q;
        wdata   = BLANK;
        case (state_q)
            CLEAR: begin
                we = 1'b1;
                if (k_q == LAST) begin
                    state_d = IDLE;
                    k_d     = 8'd0;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            SCROLL: begin
                we    = 1'b1;
                wdata = (k_q < SHIFT_END) ? mem_q[src_idx] : BLANK;
                if (k_q == LAST) begin
                    state_d = IDLE;
                    k_d     = 8'd0;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        we    = 1'b1;
                        waddr = cur_idx;
                        wdata = in_data;
                        if (col_q < COL_MAX) begin
                            col_d = col_q + 5'd1;
                        end else begin
                            col_d = 5'd0;
                            if (row_q < ROW_MAX) begin
                                row_d = row_q + 3'd1;
                            end else begin
                                state_d = SCROLL;
                                k_d     = 8'd0;
                            end
                        end
                    end else if (in_data == 8'h0A || in_data == 8'h0D) begin
                        col_d = 5'd0;
                        if (row_q < ROW_MAX) begin
                            row_d = row_q + 3'd1;
                        end else begin
                            state_d = SCROLL;
                            k_d     = 8'd0;
                        end
                    end else if (in_data == 8'h08) begin
                        if (col_q != 5'd0) begin
                            col_d = col_q - 5'd1;
                            we    = 1'b1;
                            waddr = cell_idx(row_q, col_q - 5'd1);
                        end else if (row_q != 3'd0) begin
                            row_d = row_q - 3'd1;
                            col_d = COL_MAX;
                            we    = 1'b1;
                            waddr = cell_idx(row_q - 3'd1, COL_MAX);
                        end
                    end else if (in_data == 8'h0C) begin
                        state_d = CLEAR;
                        k_d     = 8'd0;
                        row_d   = 3'd0;
                        col_d   = 5'd0;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                k_d     = 8'd0;
            end
        endcase
    end

    // Control state; reset restarts the clear sweep from cell 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            k_q     <= 8'd0;
            row_q   <= 3'd0;
            col_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Cell array write port.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered display read, one cycle latency, blank outside the screen.
    always_ff @(posedge clk) begin
        if (reset || rd_oob) begin
            charout_q <= BLANK;
        end else begin
            charout_q <= mem_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: a screen model updated per accepted byte, a read
// scoreboard (queue of expected charout values) drained by a separate monitor.
module tb_text_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] rin;
    logic [5:0] cin;
    logic [7:0] charout;
    logic [2:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;

    always #5 clk = ~clk;

    text_buffer dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rin(rin), .cin(cin), .charout(charout),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_cell [7][20];
    int         m_row, m_col;
    logic [7:0] exp_q [$];
    bit         rd_req = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_blank();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++) m_cell[r][c] = 8'h20;
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic void model_scroll();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 20; c++) m_cell[r][c] = m_cell[r+1][c];
        for (int c = 0; c < 20; c++) m_cell[6][c] = 8'h20;
    endfunction

    // Screen effect of one accepted byte; returns 1 when a sweep begins.
    function automatic bit model_apply(input logic [7:0] b);
        bit sw = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_cell[m_row][m_col] = b;
            if (m_col < 19) m_col++;
            else begin
                m_col = 0;
                if (m_row < 6) m_row++;
                else begin model_scroll(); sw = 1'b1; end
            end
        end else if (b == 8'h0A || b == 8'h0D) begin
            m_col = 0;
            if (m_row < 6) m_row++;
            else begin model_scroll(); sw = 1'b1; end
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_cell[m_row][m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = 19;
                m_cell[m_row][m_col] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            model_blank();
            sw = 1'b1;
        end
        return sw;
    endfunction

    // Monitor: every cycle a read was presented, compare charout one cycle later.
    always @(posedge clk) begin
        if (rd_req) begin
            logic [7:0] e;
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL charout_unexpected: got %0h expected none", charout);
            end else begin
                e = exp_q.pop_front();
                chk("charout", {24'd0, charout}, {24'd0, e});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, output bit sw);
        wait_idle();
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        sw = model_apply(b);
    endtask

    task automatic check_cursor(input string nm);
        chk({nm, "_row"}, {29'd0, cur_row}, m_row);
        chk({nm, "_col"}, {27'd0, cur_col}, m_col);
    endtask

    // Called on the first negedge of a sweep: busy must last exactly 140 cycles.
    task automatic expect_sweep(input string nm);
        int n = 0;
        int rdy = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (in_ready !== 1'b0) rdy++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_len"}, n, 140);
        chk({nm, "_rdy_low"}, rdy, 0);
        chk({nm, "_rdy_up"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic rd(input int r, input int c);
        rin    = r[3:0];
        cin    = c[5:0];
        rd_req = 1'b1;
        if (r >= 7 || c >= 20) exp_q.push_back(8'h20);
        else exp_q.push_back(m_cell[r][c]);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic rd_all();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++) rd(r, c);
    endtask

    initial begin
        bit         sw;
        int         n;
        logic [7:0] b;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; rin = 4'd0; cin = 6'd0;

        // Reset one cycle, then a full clear sweep.
        @(negedge clk);
        reset = 1'b0;
        model_blank();
        chk("rst_charout", {24'd0, charout}, 32'h20);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        check_cursor("rst");
        expect_sweep("clear");
        rd_all();

        // "AB" and out-of-range reads.
        send(8'h41, sw);
        send(8'h42, sw);
        rd(0, 0); rd(0, 1);
        check_cursor("ab");
        rd(7, 0); rd(0, 20); rd(15, 63);

        // Backspace, including at the origin and across a row boundary.
        send(8'h08, sw); check_cursor("bs1");
        send(8'h08, sw); check_cursor("bs2");
        send(8'h08, sw); check_cursor("bs3");
        rd(0, 0); rd(0, 1);
        repeat (20) send(8'h78, sw);
        check_cursor("row_wrap");
        send(8'h08, sw); check_cursor("bs_wrap");
        rd(0, 18); rd(0, 19); rd(1, 0);

        // Form feed, then fill the screen to force a scroll.
        send(8'h0C, sw);
        expect_sweep("ff1");
        for (int i = 0; i < 140; i++) send(8'h61 + 8'(i / 20), sw);
        expect_sweep("fill_scroll");
        check_cursor("after_scroll");
        rd_all();
        send(8'h7A, sw);
        rd(6, 0);

        // Hold a byte on in_valid through a scroll.
        send(8'h0A, sw);
        in_data  = 8'h41;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("hold_wait", n, 140);
        repeat (3) begin
            @(negedge clk);
            void'(model_apply(8'h41));
        end
        in_valid = 1'b0;
        check_cursor("hold");
        for (int c = 0; c < 5; c++) rd(6, c);

        // Reset 50 cycles into a scroll.
        send(8'h0A, sw);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_blank();
        expect_sweep("rst_mid");
        check_cursor("rst_mid");
        rd_all();

        // Form feed with text present.
        send(8'h48, sw); send(8'h49, sw); send(8'h0A, sw); send(8'h4A, sw);
        rd(0, 1); rd(1, 0);
        send(8'h0C, sw);
        expect_sweep("ff2");
        check_cursor("ff2");
        rd_all();

        // Randomized byte stream.
        repeat (400) begin
            case ($urandom_range(0, 19))
                13, 14:  b = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
                15, 16:  b = 8'h08;
                17:      b = 8'h7F + 8'($urandom_range(0, 128));
                18:      b = 8'($urandom_range(0, 7));
                19:      b = ($urandom_range(0, 9) == 0) ? 8'h0C : 8'h2E;
                default: b = 8'($urandom_range(32, 126));
            endcase
            send(b, sw);
            check_cursor("rnd");
            if (sw) expect_sweep("rnd_sweep");
            if ($urandom_range(0, 5) == 0)
                repeat (4) rd($urandom_range(0, 8), $urandom_range(0, 22));
        end
        rd_all();

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character-cell store that sits directly upstream of the pixel/glyph mapper.
- Accepts a byte stream from the input side (UART/keyboard receiver) over a valid/ready handshake.
- Maintains a 7-row x 20-column screen of 8-bit character codes with a cursor, newline, backspace, clear and scroll-up.
- Serves the mapper's row/column lookup (rin/cin) with the character code (charout) for each cell.

Parameters:
- ROWS, 7, number of text rows.
- COLS, 20, number of text columns.
- BLANK, 8'h20, code written into empty cells.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  incoming character or control byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a byte this cycle.
- rin  input  4  display row to read (from mapper).
- cin  input  6  display column to read (from mapper).
- charout  output  8  character code at (rin, cin), registered.
- cur_row  output  3  cursor row, 0..ROWS-1.
- cur_col  output  5  cursor column, 0..COLS-1.
- busy  output  1  clear or scroll sweep in progress.

Behaviour:
- Storage: ROWS*COLS = 140 cells. Cell index = row*COLS + col. There is one write port. The display read port is independent of the write port.
- Read: charout <= cell[rin*COLS+cin] on every clock, giving 1-cycle latency. If rin>=ROWS or cin>=COLS, then charout <= BLANK. The read port is live in every state, including during a sweep.
- Handshake:
  - in_ready = (state==IDLE) && !reset.
  - A byte is accepted only on a cycle where in_valid && in_ready.
  - in_data is ignored at all other times and is never queued.
- States: CLEAR, IDLE, SCROLL. busy = (state != IDLE).
- Reset:
  - Enter CLEAR with sweep index k=0.
  - cur_row=0, cur_col=0, charout=BLANK, in_ready=0, busy=1.
  - Reset asserted mid-sweep or mid-scroll restarts CLEAR at k=0.
- CLEAR:
  - Each cycle writes cell[k]=BLANK, then k++.
  - After k=139 is written, go to IDLE. The sweep takes exactly 140 cycles.
  - in_ready rises on the cycle after the last write.
- SCROLL:
  - For k=0..119, each cycle does cell[k] <= cell[k+COLS].
  - For k=120..139, each cycle writes BLANK.
  - After 140 cycles, go to IDLE.
  - The cursor is unchanged during the sweep.
- IDLE, accepted byte b:
  - Printable (0x20..0x7E):
    - Write cell[cur]=b.
    - If cur_col<19, then cur_col++.
    - Otherwise cur_col=0, and:
      - if cur_row<6, then cur_row++;
      - if cur_row==6, it stays 6 and the block enters SCROLL.
  - 0x0A or 0x0D: cur_col=0, then:
    - if cur_row<6, then cur_row++;
    - else the block enters SCROLL with cur_row=6.
  - 0x08 (backspace):
    - If cur_col>0: cur_col--, and write BLANK at the new position.
    - Else if cur_row>0: cur_row--, cur_col=19, and write BLANK there.
    - Else (0,0): no change.
  - 0x0C: enter CLEAR with k=0, cursor set to (0,0).
  - Any other code is accepted and has no effect.
- Cursor update and cell write happen in the same cycle as acceptance. A read of the written cell in the following cycle returns the new value.
- Width rules:
  - Index arithmetic is at least 8 bits wide.
  - rin and cin are zero-extended before the multiply-add.
  - Out-of-range checks are done on the full rin/cin widths.

Test Plan:
1. Reset for 1 cycle, release -> busy=1 and in_ready=0 for exactly 140 cycles, then in_ready=1. A read of every (r,c) returns 8'h20. Cursor reads (0,0).
2. Send "AB" (0x41, 0x42), then read rin=0 with cin=0 and cin=1 -> charout 0x41 and 0x42 one cycle after each address. Cursor reads (0,2). Reading rin=7 or cin=20 -> 0x20.
3. Send 0x08 twice, then 0x08 at (0,0) -> cursor goes (0,1), then (0,0), then stays (0,0). Cells (0,0) and (0,1) read 0x20. A backspace from (1,0) lands at (0,19) and blanks it.
4. Fill 140 printable bytes 'a'+row, then send one more byte 'z' at cursor (6,0) after the scroll -> after byte 140, busy is high for 140 cycles. Row 0 now holds 'b', row 5 holds 'g', row 6 holds blanks. Cursor reads (6,0). Then 'z' appears at (6,0).
5. Hold in_valid=1 with 0x41 during a SCROLL -> no byte is accepted until in_ready=1. Exactly one write occurs per cycle of in_valid&&in_ready after that.
6. Assert reset at cycle 50 of a SCROLL, and separately send 0x0C with text present -> a full 140-cycle CLEAR runs from index 0. All cells read 0x20. Cursor reads (0,0).
